// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  // Clock cycles per bit; truncating division.
  function automatic int bit_cyc(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// N-flop synchronizer for asynchronous input pins; reset value selects the idle level.
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_ff: STAGES must be at least 2");
  end

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= {STAGES{RST_VAL}};
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx_frame.sv
// UART 8N1 receiver: synchronizes the serial line, samples mid-bit, and emits one
// registered byte per good frame; framing errors raise a strobe and are not forwarded.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BAUD        = 9600,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   RX_Pin_In,
  output logic [UART_DATA_W-1:0] RX_Data,
  output logic                   RX_Done_Sig,
  output logic                   Frame_Err,
  output logic                   RX_Busy,
  output rx_state_t              state_dbg
);

  localparam int BIT_CYC = bit_cyc(CLK_HZ, BAUD);
  localparam int CNT_W   = $clog2(BIT_CYC);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYC / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BIT_CYC - 1);

  if (BIT_CYC < 8) begin : g_bad_baud
    $error("uart_rx_frame: CLK_HZ/BAUD must be at least 8");
  end

  logic                   rx_s;
  logic                   rx_prev;
  rx_state_t              state;
  logic [CNT_W-1:0]       clk_cnt;
  logic [2:0]             bit_idx;
  logic [UART_DATA_W-1:0] shreg;

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
    .clk   (CLK),
    .rst_n (RSTn),
    .d     (RX_Pin_In),
    .q     (rx_s)
  );

  // rx_prev resets high so a line already low at release needs a fresh fall.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state       <= IDLE;
      rx_prev     <= 1'b1;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      RX_Data     <= '0;
      RX_Done_Sig <= 1'b0;
      Frame_Err   <= 1'b0;
      RX_Busy     <= 1'b0;
    end else begin
      rx_prev     <= rx_s;
      RX_Done_Sig <= 1'b0;
      Frame_Err   <= 1'b0;
      unique case (state)
        IDLE: begin
          clk_cnt <= '0;
          if (rx_prev && !rx_s) begin
            state   <= START;
            RX_Busy <= 1'b1;
          end
        end
        START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            if (rx_s) begin
              state   <= IDLE;
              RX_Busy <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == FULL_LAST) begin
            clk_cnt <= '0;
            shreg   <= {rx_s, shreg[UART_DATA_W-1:1]};
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (clk_cnt == FULL_LAST) begin
            clk_cnt <= '0;
            if (rx_s) begin
              RX_Data     <= shreg;
              RX_Done_Sig <= 1'b1;
              state       <= IDLE;
              RX_Busy     <= 1'b0;
            end else begin
              Frame_Err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        BREAK: begin
          clk_cnt <= '0;
          if (rx_s) begin
            state   <= IDLE;
            RX_Busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          clk_cnt <= '0;
          RX_Busy <= 1'b0;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at 16 clocks per bit; a negedge monitor scores
// every RX_Done_Sig strobe against a queue of expected bytes.
module tb_uart_rx_frame;
  import uart_pkg::*;

  localparam int CLK_NS = 10;
  localparam int BIT_NS = 16 * CLK_NS;

  logic       clk;
  logic       rst_n;
  logic       rx_pin;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;
  rx_state_t  state_dbg;

  int checks = 0;
  int passes = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  logic prev_pulse = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx_frame #(.CLK_HZ(1_000_000), .BAUD(62_500), .SYNC_STAGES(2)) dut (
    .CLK         (clk),
    .RSTn        (rst_n),
    .RX_Pin_In   (rx_pin),
    .RX_Data     (rx_data),
    .RX_Done_Sig (rx_done),
    .Frame_Err   (frame_err),
    .RX_Busy     (rx_busy),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #(CLK_NS / 2) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // driver: start bit, 8 data bits LSB first, stop bit; line left at the stop level
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int bit_ns);
    rx_pin = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx_pin = d[i];
      #(bit_ns);
    end
    rx_pin = stop_bit;
    #(bit_ns);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (rx_done || frame_err) begin
      check("strobe_exclusive", {31'd0, rx_done & frame_err}, 32'd0);
      check("strobe_not_back_to_back", {31'd0, prev_pulse}, 32'd0);
    end
    if (rx_done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        check("rx_byte", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
    end
    if (frame_err) ferr_cnt++;
    prev_pulse = rx_done | frame_err;
  end

  initial begin
    rst_n  = 1'b0;
    rx_pin = 1'b1;
    #25;
    check("rst_data", {24'd0, rx_data}, 32'h00);
    check("rst_done", {31'd0, rx_done}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, rx_busy}, 32'd0);
    check("rst_state", {29'd0, state_dbg}, {29'd0, IDLE});
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(5);

    // single good frame
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, BIT_NS);
    wait_cycles(5);
    check("t1_done_cnt", done_cnt, 32'd1);
    check("t1_data", {24'd0, rx_data}, 32'h55);
    check("t1_ferr_cnt", ferr_cnt, 32'd0);
    check("t1_busy", {31'd0, rx_busy}, 32'd0);

    // back-to-back frames
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h00);
    send_frame(8'hA3, 1'b1, BIT_NS);
    send_frame(8'h00, 1'b1, BIT_NS);
    wait_cycles(5);
    check("t2_done_cnt", done_cnt, 32'd3);
    check("t2_data", {24'd0, rx_data}, 32'h00);

    // 4-cycle glitch
    rx_pin = 1'b0;
    #(4 * CLK_NS);
    rx_pin = 1'b1;
    wait_cycles(12);
    check("t3_busy", {31'd0, rx_busy}, 32'd0);
    check("t3_state", {29'd0, state_dbg}, {29'd0, IDLE});
    check("t3_done_cnt", done_cnt, 32'd3);
    check("t3_data", {24'd0, rx_data}, 32'h00);

    // good frame, then framing error with the line held low
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, BIT_NS);
    send_frame(8'hFF, 1'b0, BIT_NS);
    #(40 * CLK_NS);
    check("t4_state_break", {29'd0, state_dbg}, {29'd0, BREAK});
    check("t4_busy_break", {31'd0, rx_busy}, 32'd1);
    check("t4_ferr_cnt", ferr_cnt, 32'd1);
    check("t4_done_cnt", done_cnt, 32'd4);
    check("t4_data_kept", {24'd0, rx_data}, 32'h3C);
    rx_pin = 1'b1;
    wait_cycles(6);
    check("t4_state_idle", {29'd0, state_dbg}, {29'd0, IDLE});
    check("t4_busy_idle", {31'd0, rx_busy}, 32'd0);

    // reset during data bit 4 of 0xF0
    rx_pin = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx_pin = 1'b0;
      #(BIT_NS);
    end
    rx_pin = 1'b1;
    #(BIT_NS / 2);
    rst_n = 1'b0;
    #(3 * CLK_NS);
    check("t5_rst_data", {24'd0, rx_data}, 32'h00);
    check("t5_rst_busy", {31'd0, rx_busy}, 32'd0);
    check("t5_rst_state", {29'd0, state_dbg}, {29'd0, IDLE});
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(20);
    check("t5_no_strobe", done_cnt, 32'd4);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, BIT_NS);
    wait_cycles(5);
    check("t5_done_cnt", done_cnt, 32'd5);
    check("t5_data", {24'd0, rx_data}, 32'h81);

    // +/-3% baud skew
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1, 155);
    wait_cycles(5);
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1, 165);
    wait_cycles(5);
    check("t6_done_cnt", done_cnt, 32'd7);
    check("t6_data", {24'd0, rx_data}, 32'h96);
    check("t6_ferr_cnt", ferr_cnt, 32'd1);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
